parity_frame_chk: RTL and testbench

PARITY_FRAME_CHK -- requirements
Module: parity_frame_chk

---
 rtl/parity_frame_chk.sv | 125 ++++++++++++
 tb/tb_parity_frame_chk.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/parity_frame_chk.sv
// parity_frame_chk
// Multi-lane serial parity checker. Each lane accumulates a running XOR of the
// bits accepted in the current frame. On the last bit of a frame, the block
// compares the final lane parity against the expected sense (even or odd). It
// latches a per-lane error vector, pulses frame_done for one cycle and bumps a
// saturating count of bad frames.

module parity_frame_chk #(
    parameter int CHANNELS  = 4,
    parameter int FRAME_LEN = 8,
    parameter int ODD_MODE  = 0,
    localparam int CNT_W    = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] x,
    input  logic                x_valid,
    input  logic                clear,
    output logic [CHANNELS-1:0] z,
    output logic [CNT_W-1:0]    bit_cnt,
    output logic                frame_done,
    output logic [CHANNELS-1:0] parity_err,
    output logic [7:0]          err_count
);

    // Index of the parity bit, i.e. the last bit of a frame.
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic             ODD_BIT  = (ODD_MODE != 0);
    localparam logic [7:0]       ERR_MAX  = 8'hFF;
    localparam logic [7:0]       ERR_ONE  = 8'h01;

    logic [CHANNELS-1:0] z_reg,          z_next;
    logic [CNT_W-1:0]    bit_cnt_reg,    bit_cnt_next;
    logic                frame_done_reg, frame_done_next;
    logic [CHANNELS-1:0] parity_err_reg, parity_err_next;
    logic [7:0]          err_count_reg,  err_count_next;

    // A bit is taken only when valid and not overridden by clear; reset
    // priority is applied in the register block.
    logic                accept;
    logic                last_bit;
    logic                frame_end;
    logic [CHANNELS-1:0] final_err;
    logic                frame_bad;

    // Frame control decode shared by all lanes.
    always_comb begin
        accept    = x_valid & ~clear;
        last_bit  = (bit_cnt_reg == LAST_IDX);
        frame_end = accept & last_bit;
        frame_bad = |final_err;
    end

    // Per-lane running parity and end-of-frame error evaluation.
    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
            // Error for this lane if the frame ended with this bit.
            always_comb begin
                final_err[gi] = z_reg[gi] ^ x[gi] ^ ODD_BIT;
            end

            // Next running parity and latched error for this lane.
            always_comb begin
                z_next[gi]          = z_reg[gi];
                parity_err_next[gi] = parity_err_reg[gi];
                if (clear) begin
                    z_next[gi]          = 1'b0;
                    parity_err_next[gi] = 1'b0;
                end else if (accept) begin
                    if (last_bit) begin
                        z_next[gi]          = 1'b0;
                        parity_err_next[gi] = final_err[gi];
                    end else begin
                        z_next[gi] = z_reg[gi] ^ x[gi];
                    end
                end
            end
        end
    endgenerate

    // Bit counter, completion pulse and saturating bad-frame counter.
    always_comb begin
        bit_cnt_next    = bit_cnt_reg;
        frame_done_next = 1'b0;
        err_count_next  = err_count_reg;
        if (clear) begin
            bit_cnt_next = '0;
        end else if (accept) begin
            if (last_bit) begin
                bit_cnt_next    = '0;
                frame_done_next = 1'b1;
            end else begin
                bit_cnt_next = bit_cnt_reg + CNT_ONE;
            end
        end
        if (frame_end && frame_bad && (err_count_reg != ERR_MAX)) begin
            err_count_next = err_count_reg + ERR_ONE;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            z_reg          <= '0;
            bit_cnt_reg    <= '0;
            frame_done_reg <= 1'b0;
            parity_err_reg <= '0;
            err_count_reg  <= '0;
        end else begin
            z_reg          <= z_next;
            bit_cnt_reg    <= bit_cnt_next;
            frame_done_reg <= frame_done_next;
            parity_err_reg <= parity_err_next;
            err_count_reg  <= err_count_next;
        end
    end

    assign z          = z_reg;
    assign bit_cnt    = bit_cnt_reg;
    assign frame_done = frame_done_reg;
    assign parity_err = parity_err_reg;
    assign err_count  = err_count_reg;

endmodule

// File: tb/tb_parity_frame_chk.sv
// Directed bench for parity_frame_chk with CHANNELS=2, FRAME_LEN=4. An even and
// an odd instance share the same stimulus. Observed outputs are packed as
// {z, bit_cnt, frame_done, parity_err, err_count}.

module tb_parity_frame_chk;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] x;
    logic       x_valid;
    logic       clear;

    logic [1:0] z_e, z_o, cnt_e, cnt_o, pe_e, pe_o;
    logic       fd_e, fd_o;
    logic [7:0] ec_e, ec_o;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    parity_frame_chk #(.CHANNELS(2), .FRAME_LEN(4), .ODD_MODE(0)) dut_e (
        .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .clear(clear),
        .z(z_e), .bit_cnt(cnt_e), .frame_done(fd_e), .parity_err(pe_e), .err_count(ec_e)
    );

    parity_frame_chk #(.CHANNELS(2), .FRAME_LEN(4), .ODD_MODE(1)) dut_o (
        .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .clear(clear),
        .z(z_o), .bit_cnt(cnt_o), .frame_done(fd_o), .parity_err(pe_o), .err_count(ec_o)
    );

    wire [14:0] obs_e = {z_e, cnt_e, fd_e, pe_e, ec_e};
    wire [14:0] obs_o = {z_o, cnt_o, fd_o, pe_o, ec_o};

    // Frame A: lane0 1,0,1,0  lane1 1,1,1,0  (vector is {lane1,lane0})
    logic [1:0] frame_a [4] = '{2'b11, 2'b10, 2'b11, 2'b00};
    logic [1:0] za_tab  [4] = '{2'b11, 2'b01, 2'b10, 2'b00};
    // Frame B: even ones in both lanes
    logic [1:0] frame_b [4] = '{2'b11, 2'b11, 2'b00, 2'b00};
    logic [1:0] zb_tab  [4] = '{2'b11, 2'b00, 2'b00, 2'b00};

    function automatic logic [14:0] pk(input logic [1:0] zz, input logic [1:0] cc,
                                       input logic ff, input logic [1:0] pp,
                                       input logic [7:0] ee);
        return {zz, cc, ff, pp, ee};
    endfunction

    // Drive one cycle of inputs, clock it, and settle past the edge.
    task automatic step(input logic [1:0] xv, input logic v, input logic c, input logic r);
        x       = xv;
        x_valid = v;
        clear   = c;
        rst     = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step(2'b00, 1'b0, 1'b0, 1'b1);
        step(2'b00, 1'b0, 1'b0, 1'b1);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        step(2'b11, 1'b1, 1'b0, 1'b1);
        step(2'b11, 1'b1, 1'b1, 1'b1);
        n_checks++;
        if (obs_e !== 15'h0) $display("FAIL reset_even: got %h want %h", obs_e, 15'h0);
        else n_pass++;
        n_checks++;
        if (obs_o !== 15'h0) $display("FAIL reset_odd: got %h want %h", obs_o, 15'h0);
        else n_pass++;
        rst = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_basic();
        logic [14:0] ee, eo;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            step(frame_a[k], 1'b1, 1'b0, 1'b0);
            ee = (k == 3) ? pk(2'b00, 2'd0, 1'b1, 2'b10, 8'd1) : pk(za_tab[k], 2'(k + 1), 1'b0, 2'b00, 8'd0);
            eo = (k == 3) ? pk(2'b00, 2'd0, 1'b1, 2'b01, 8'd1) : pk(za_tab[k], 2'(k + 1), 1'b0, 2'b00, 8'd0);
            n_checks++;
            if (obs_e !== ee) $display("FAIL basic_even bit%0d: got %h want %h", k, obs_e, ee);
            else n_pass++;
            n_checks++;
            if (obs_o !== eo) $display("FAIL basic_odd bit%0d: got %h want %h", k, obs_o, eo);
            else n_pass++;
        end
        // Idle cycle: pulse drops, results hold.
        step(2'b11, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (obs_e !== pk(2'b00, 2'd0, 1'b0, 2'b10, 8'd1))
            $display("FAIL basic_hold_even: got %h want %h", obs_e, pk(2'b00, 2'd0, 1'b0, 2'b10, 8'd1));
        else n_pass++;
        n_checks++;
        if (obs_o !== pk(2'b00, 2'd0, 1'b0, 2'b01, 8'd1))
            $display("FAIL basic_hold_odd: got %h want %h", obs_o, pk(2'b00, 2'd0, 1'b0, 2'b01, 8'd1));
        else n_pass++;
        $display("test_basic done: pe_e=%b pe_o=%b ec=%0d", pe_e, pe_o, ec_e);
    endtask

    task automatic test_gaps();
        int gaps [5] = '{0, 3, 5, 2, 4};
        logic [14:0] held_e, held_o, ee, eo;
        do_reset();
        held_e = 15'h0;
        held_o = 15'h0;
        for (int k = 0; k < 5; k++) begin
            for (int g = 0; g < gaps[k]; g++) begin
                step(2'($urandom_range(0, 3)), 1'b0, 1'b0, 1'b0);
                n_checks++;
                if (obs_e !== held_e) $display("FAIL gap_even k%0d g%0d: got %h want %h", k, g, obs_e, held_e);
                else n_pass++;
                n_checks++;
                if (obs_o !== held_o) $display("FAIL gap_odd k%0d g%0d: got %h want %h", k, g, obs_o, held_o);
                else n_pass++;
            end
            if (k < 4) begin
                step(frame_a[k], 1'b1, 1'b0, 1'b0);
                ee = (k == 3) ? pk(2'b00, 2'd0, 1'b1, 2'b10, 8'd1) : pk(za_tab[k], 2'(k + 1), 1'b0, 2'b00, 8'd0);
                eo = (k == 3) ? pk(2'b00, 2'd0, 1'b1, 2'b01, 8'd1) : pk(za_tab[k], 2'(k + 1), 1'b0, 2'b00, 8'd0);
                n_checks++;
                if (obs_e !== ee) $display("FAIL gap_bit_even bit%0d: got %h want %h", k, obs_e, ee);
                else n_pass++;
                n_checks++;
                if (obs_o !== eo) $display("FAIL gap_bit_odd bit%0d: got %h want %h", k, obs_o, eo);
                else n_pass++;
                held_e = {ee[14:11], 1'b0, ee[9:0]};
                held_o = {eo[14:11], 1'b0, eo[9:0]};
            end
        end
        $display("test_gaps done");
    endtask

    task automatic test_clear();
        logic [14:0] ee, eo;
        do_reset();
        for (int k = 0; k < 4; k++) step(frame_a[k], 1'b1, 1'b0, 1'b0);
        // Two bits of a frame that will be aborted.
        step(frame_a[0], 1'b1, 1'b0, 1'b0);
        step(frame_a[1], 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (obs_e !== pk(2'b01, 2'd2, 1'b0, 2'b10, 8'd1))
            $display("FAIL clear_pre_even: got %h want %h", obs_e, pk(2'b01, 2'd2, 1'b0, 2'b10, 8'd1));
        else n_pass++;
        // Clear wins over a valid bit in the same cycle.
        step(2'b11, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (obs_e !== pk(2'b00, 2'd0, 1'b0, 2'b00, 8'd1))
            $display("FAIL clear_even: got %h want %h", obs_e, pk(2'b00, 2'd0, 1'b0, 2'b00, 8'd1));
        else n_pass++;
        n_checks++;
        if (obs_o !== pk(2'b00, 2'd0, 1'b0, 2'b00, 8'd1))
            $display("FAIL clear_odd: got %h want %h", obs_o, pk(2'b00, 2'd0, 1'b0, 2'b00, 8'd1));
        else n_pass++;
        for (int k = 0; k < 4; k++) begin
            step(frame_b[k], 1'b1, 1'b0, 1'b0);
            ee = (k == 3) ? pk(2'b00, 2'd0, 1'b1, 2'b00, 8'd1) : pk(zb_tab[k], 2'(k + 1), 1'b0, 2'b00, 8'd1);
            eo = (k == 3) ? pk(2'b00, 2'd0, 1'b1, 2'b11, 8'd2) : pk(zb_tab[k], 2'(k + 1), 1'b0, 2'b00, 8'd1);
            n_checks++;
            if (obs_e !== ee) $display("FAIL clear_frame_even bit%0d: got %h want %h", k, obs_e, ee);
            else n_pass++;
            n_checks++;
            if (obs_o !== eo) $display("FAIL clear_frame_odd bit%0d: got %h want %h", k, obs_o, eo);
            else n_pass++;
        end
        $display("test_clear done: pe_e=%b ec_e=%0d", pe_e, ec_e);
    endtask

    task automatic test_rst_mid_frame();
        logic [14:0] ee;
        do_reset();
        for (int k = 0; k < 4; k++) step(frame_a[k], 1'b1, 1'b0, 1'b0);
        step(frame_a[0], 1'b1, 1'b0, 1'b0);
        step(frame_a[1], 1'b1, 1'b0, 1'b0);
        step(2'b11, 1'b1, 1'b1, 1'b1);
        n_checks++;
        if (obs_e !== 15'h0) $display("FAIL rst_mid_even: got %h want %h", obs_e, 15'h0);
        else n_pass++;
        n_checks++;
        if (obs_o !== 15'h0) $display("FAIL rst_mid_odd: got %h want %h", obs_o, 15'h0);
        else n_pass++;
        for (int k = 0; k < 4; k++) begin
            step(frame_a[k], 1'b1, 1'b0, 1'b0);
            ee = (k == 3) ? pk(2'b00, 2'd0, 1'b1, 2'b10, 8'd1) : pk(za_tab[k], 2'(k + 1), 1'b0, 2'b00, 8'd0);
            n_checks++;
            if (obs_e !== ee) $display("FAIL rst_fresh_even bit%0d: got %h want %h", k, obs_e, ee);
            else n_pass++;
        end
        $display("test_rst_mid_frame done");
    endtask

    task automatic test_back_to_back();
        int          fd_cnt_e = 0;
        int          fd_cnt_o = 0;
        int          done;
        logic [1:0]  pe_exp_e, pe_exp_o;
        logic [7:0]  ec_exp;
        logic [14:0] ee, eo;
        do_reset();
        for (int f = 0; f < 260; f++) begin
            for (int k = 0; k < 4; k++) begin
                step(frame_a[k], 1'b1, 1'b0, 1'b0);
                if (fd_e) fd_cnt_e++;
                if (fd_o) fd_cnt_o++;
                done     = (k == 3) ? f + 1 : f;
                ec_exp   = (done > 255) ? 8'd255 : 8'(done);
                pe_exp_e = (done > 0) ? 2'b10 : 2'b00;
                pe_exp_o = (done > 0) ? 2'b01 : 2'b00;
                ee = pk((k == 3) ? 2'b00 : za_tab[k], 2'((k + 1) % 4), (k == 3), pe_exp_e, ec_exp);
                eo = pk((k == 3) ? 2'b00 : za_tab[k], 2'((k + 1) % 4), (k == 3), pe_exp_o, ec_exp);
                n_checks++;
                if (obs_e !== ee) $display("FAIL b2b_even f%0d bit%0d: got %h want %h", f, k, obs_e, ee);
                else n_pass++;
                n_checks++;
                if (obs_o !== eo) $display("FAIL b2b_odd f%0d bit%0d: got %h want %h", f, k, obs_o, eo);
                else n_pass++;
            end
            if (f >= 253) $display("frame %0d: ec_e=%0d ec_o=%0d", f, ec_e, ec_o);
        end
        step(2'b00, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (ec_e !== 8'd255) $display("FAIL sat_hold_even: got %0d want 255", ec_e);
        else n_pass++;
        n_checks++;
        if (fd_cnt_e != 260) $display("FAIL fd_pulses_even: got %0d want 260", fd_cnt_e);
        else n_pass++;
        n_checks++;
        if (fd_cnt_o != 260) $display("FAIL fd_pulses_odd: got %0d want 260", fd_cnt_o);
        else n_pass++;
        $display("test_back_to_back done: pulses=%0d ec=%0d", fd_cnt_e, ec_e);
    endtask

    initial begin
        rst     = 1'b1;
        x       = 2'b00;
        x_valid = 1'b0;
        clear   = 1'b0;
        test_reset();
        test_basic();
        test_gaps();
        test_clear();
        test_rst_mid_frame();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
